// File: rtl/fifo_pkg.sv
// Shared constants for fifo_prog: output-mode selectors and occupancy width helper.
package fifo_pkg;

  localparam int FIFO_OUT_FWFT = 0;
  localparam int FIFO_OUT_REG  = 1;

  // Occupancy must represent FIFO_SIZE itself, so it needs one bit beyond the pointer.
  function automatic int cnt_w(input int addr_len);
    return addr_len + 1;
  endfunction

endpackage

// File: rtl/fifo_prog_if.sv
// Request/status bundle between a producer/consumer and fifo_prog.
interface fifo_prog_if #(
  parameter int DATA_SIZE     = 49,
  parameter int FIFO_ADDR_LEN = 3
);

  logic                     ENQ;
  logic                     DEQ;
  logic                     FLUSH;
  logic                     CLR_ERR;
  logic [DATA_SIZE-1:0]     DI;
  logic [FIFO_ADDR_LEN:0]   AF_TH;
  logic [FIFO_ADDR_LEN:0]   AE_TH;
  logic [FIFO_ADDR_LEN:0]   CNT;
  logic                     EMPTY;
  logic                     FULL;
  logic                     AFULL;
  logic                     AEMPTY;
  logic                     OVF;
  logic                     UDF;
  logic [DATA_SIZE-1:0]     DO;
  logic                     DO_VLD;

  modport master (
    output ENQ, DEQ, FLUSH, CLR_ERR, DI, AF_TH, AE_TH,
    input  CNT, EMPTY, FULL, AFULL, AEMPTY, OVF, UDF, DO, DO_VLD
  );

  modport slave (
    input  ENQ, DEQ, FLUSH, CLR_ERR, DI, AF_TH, AE_TH,
    output CNT, EMPTY, FULL, AFULL, AEMPTY, OVF, UDF, DO, DO_VLD
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Ring pointer over 0..FIFO_SIZE-1 with explicit wrap; advances one slot per inc.
// clr (flush) returns it to slot 0; reset does the same.
module fifo_wrap_ptr #(
  parameter int FIFO_SIZE     = 8,
  parameter int FIFO_ADDR_LEN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [FIFO_ADDR_LEN-1:0] ptr
);

  localparam logic [FIFO_ADDR_LEN-1:0] LAST_C = FIFO_ADDR_LEN'(FIFO_SIZE - 1);

  logic [FIFO_ADDR_LEN-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST_C) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO, any depth >= 2, programmable AF/AE, flush, sticky OVF/UDF.
// Latency: FWFT head visible combinationally or registered DO one cycle after DEQ; ENQ accepted when full only alongside DEQ.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE     = 49,
  parameter int FIFO_SIZE     = 8,
  parameter int FIFO_ADDR_LEN = 3,
  parameter int OUT_REG       = FIFO_OUT_FWFT
) (
  input logic         clk,
  input logic         rst,
  fifo_prog_if.slave  bus
);

  localparam int CNT_W = cnt_w(FIFO_ADDR_LEN);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t SIZE_C = cnt_t'(FIFO_SIZE);

  logic [FIFO_ADDR_LEN-1:0] front, rear;
  logic [DATA_SIZE-1:0]     buff_q [FIFO_SIZE];
  cnt_t                     cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic                     empty, full;
  logic                     enq_ok, deq_ok;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == SIZE_C);

  // Flush swallows any same-cycle request without flagging it as an error.
  always_comb begin
    enq_ok = bus.ENQ & (~full | bus.DEQ) & ~bus.FLUSH;
    deq_ok = bus.DEQ & ~empty & ~bus.FLUSH;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (bus.FLUSH) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + cnt_t'(enq_ok) - cnt_t'(deq_ok);
    end
    if (bus.CLR_ERR) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (~bus.FLUSH & bus.ENQ & ~enq_ok) ovf_d = 1'b1;
    if (~bus.FLUSH & bus.DEQ & ~deq_ok) udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok & ~rst) begin
      buff_q[rear] <= bus.DI;
    end
  end

  fifo_wrap_ptr #(.FIFO_SIZE(FIFO_SIZE), .FIFO_ADDR_LEN(FIFO_ADDR_LEN)) u_front (
    .clk (clk),
    .rst (rst),
    .clr (bus.FLUSH),
    .inc (deq_ok),
    .ptr (front)
  );

  fifo_wrap_ptr #(.FIFO_SIZE(FIFO_SIZE), .FIFO_ADDR_LEN(FIFO_ADDR_LEN)) u_rear (
    .clk (clk),
    .rst (rst),
    .clr (bus.FLUSH),
    .inc (enq_ok),
    .ptr (rear)
  );

  assign bus.CNT    = cnt_q;
  assign bus.EMPTY  = empty;
  assign bus.FULL   = full;
  assign bus.AFULL  = (cnt_q >= bus.AF_TH);
  assign bus.AEMPTY = (cnt_q <= bus.AE_TH);
  assign bus.OVF    = ovf_q;
  assign bus.UDF    = udf_q;

  if (OUT_REG == FIFO_OUT_REG) begin : g_reg
    logic [DATA_SIZE-1:0] do_q, do_d;
    logic                 do_vld_q, do_vld_d;

    // DO keeps the last word read; DO_VLD marks only the cycle it was loaded.
    always_comb begin
      do_d     = do_q;
      do_vld_d = 1'b0;
      if (deq_ok) begin
        do_d     = buff_q[front];
        do_vld_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        do_q     <= '0;
        do_vld_q <= 1'b0;
      end else begin
        do_q     <= do_d;
        do_vld_q <= do_vld_d;
      end
    end

    assign bus.DO     = do_q;
    assign bus.DO_VLD = do_vld_q;
  end else begin : g_fwft
    assign bus.DO     = empty ? '0 : buff_q[front];
    assign bus.DO_VLD = ~empty;
  end

endmodule

// File: tb/tb_fifo_prog.sv
// Directed bench for fifo_prog: FWFT and registered-read instances, depth 6, queue scoreboards.
module tb_fifo_prog;

  localparam int DW    = 49;
  localparam int DEPTH = 6;
  localparam int AW    = 3;

  logic clk;
  logic rst;

  fifo_prog_if #(.DATA_SIZE(DW), .FIFO_ADDR_LEN(AW)) b0 ();
  fifo_prog_if #(.DATA_SIZE(DW), .FIFO_ADDR_LEN(AW)) b1 ();

  fifo_prog #(.DATA_SIZE(DW), .FIFO_SIZE(DEPTH), .FIFO_ADDR_LEN(AW), .OUT_REG(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  fifo_prog #(.DATA_SIZE(DW), .FIFO_SIZE(DEPTH), .FIFO_ADDR_LEN(AW), .OUT_REG(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            m0_ovf, m0_udf;
  bit            m1_vld, m1_udf;
  logic [DW-1:0] m1_do;
  int            af, ae;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m0_ovf = 0; m0_udf = 0;
    m1_vld = 0; m1_udf = 0; m1_do = '0;
  endtask

  task automatic idle_inputs();
    b0.ENQ = 0; b0.DEQ = 0; b0.FLUSH = 0; b0.CLR_ERR = 0; b0.DI = '0;
    b1.ENQ = 0; b1.DEQ = 0; b1.FLUSH = 0; b1.CLR_ERR = 0; b1.DI = '0;
  endtask

  task automatic post0();
    int n;
    n = q0.size();
    chk("cnt0",    64'(b0.CNT),    64'(n));
    chk("empty0",  64'(b0.EMPTY),  64'(n == 0));
    chk("full0",   64'(b0.FULL),   64'(n == DEPTH));
    chk("afull0",  64'(b0.AFULL),  64'(n >= af));
    chk("aempty0", 64'(b0.AEMPTY), 64'(n <= ae));
    chk("ovf0",    64'(b0.OVF),    64'(m0_ovf));
    chk("udf0",    64'(b0.UDF),    64'(m0_udf));
    chk("dovld0",  64'(b0.DO_VLD), 64'(n != 0));
    if (n == 0) chk("do0_empty", 64'(b0.DO), 64'd0);
    else        chk("do0_head",  64'(b0.DO), 64'(q0[0]));
    chk("front_rng", 64'(dut0.u_front.ptr_q < 3'(DEPTH)), 64'd1);
    chk("rear_rng",  64'(dut0.u_rear.ptr_q  < 3'(DEPTH)), 64'd1);
  endtask

  task automatic post1();
    chk("cnt1",   64'(b1.CNT),    64'(q1.size()));
    chk("do1",    64'(b1.DO),     64'(m1_do));
    chk("dovld1", 64'(b1.DO_VLD), 64'(m1_vld));
    chk("udf1",   64'(b1.UDF),    64'(m1_udf));
  endtask

  task automatic op0(input bit enq, input bit deq, input bit flush, input bit clr,
                     input logic [DW-1:0] di);
    bit eok, dok;
    logic [DW-1:0] tmp;
    b0.ENQ = enq; b0.DEQ = deq; b0.FLUSH = flush; b0.CLR_ERR = clr; b0.DI = di;
    b0.AF_TH = 4'(af); b0.AE_TH = 4'(ae);
    #1;
    eok = enq && (q0.size() < DEPTH || deq);
    dok = deq && (q0.size() > 0);
    if (!flush && dok) chk("pop0", 64'(b0.DO), 64'(q0[0]));
    if (clr) begin m0_ovf = 0; m0_udf = 0; end
    if (flush) begin
      q0.delete();
    end else begin
      if (dok) tmp = q0.pop_front();
      if (eok) q0.push_back(di);
      if (enq && !eok) m0_ovf = 1;
      if (deq && !dok) m0_udf = 1;
    end
    tick();
    idle_inputs();
    post0();
  endtask

  task automatic op1(input bit enq, input bit deq, input logic [DW-1:0] di);
    bit eok, dok;
    b1.ENQ = enq; b1.DEQ = deq; b1.DI = di;
    eok = enq && (q1.size() < DEPTH || deq);
    dok = deq && (q1.size() > 0);
    m1_vld = dok;
    if (dok) m1_do = q1.pop_front();
    if (eok) q1.push_back(di);
    if (deq && !dok) m1_udf = 1;
    tick();
    idle_inputs();
    post1();
  endtask

  task automatic do_reset(input bit enq_during);
    rst = 1;
    b0.ENQ = enq_during; b0.DI = 49'h7777;
    tick();
    model_reset();
    idle_inputs();
    post0();
    post1();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    af = 4; ae = 1;
    idle_inputs();
    b0.AF_TH = 4'(af); b0.AE_TH = 4'(ae);
    b1.AF_TH = 4'(af); b1.AE_TH = 4'(ae);
    tick();
    do_reset(0);

    // Fill to full, refused extra write, then drain in order
    for (int i = 1; i <= 6; i++) op0(1, 0, 0, 0, DW'(i));
    op0(1, 0, 0, 0, 49'h7);
    for (int i = 0; i < 6; i++) op0(0, 1, 0, 0, '0);
    op0(0, 0, 0, 1, '0);

    // Pointer wrap: fill 4, drain 4, fill 5, drain 5
    for (int i = 0; i < 4; i++) op0(1, 0, 0, 0, DW'(49'h100 + i));
    for (int i = 0; i < 4; i++) op0(0, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) op0(1, 0, 0, 0, DW'(49'h200 + i));
    for (int i = 0; i < 5; i++) op0(0, 1, 0, 0, '0);

    // Concurrent enqueue+dequeue while full
    for (int i = 0; i < 6; i++) op0(1, 0, 0, 0, DW'(49'h300 + i));
    op0(1, 1, 0, 0, 49'hA);
    op0(1, 1, 0, 0, 49'hB);
    op0(1, 1, 0, 0, 49'hC);
    for (int i = 0; i < 6; i++) op0(0, 1, 0, 0, '0);

    // Enqueue+dequeue on empty: only the write lands, UDF set, then cleared
    op0(1, 1, 0, 0, 49'h55);
    op0(0, 0, 0, 1, '0);
    op0(0, 1, 0, 0, '0);

    // Threshold extremes take effect immediately
    af = 0; ae = 7;
    op0(0, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) op0(1, 0, 0, 0, DW'(49'h1_0000_0000 + i));
    af = 4; ae = 1;
    op0(0, 0, 0, 0, '0);
    op0(0, 0, 1, 0, '0);

    // AF/AE thresholds across a fill, then flush with ENQ; UDF must survive flush
    op0(0, 1, 0, 0, '0);
    for (int i = 0; i < 5; i++) op0(1, 0, 0, 0, DW'(49'h400 + i));
    op0(1, 0, 1, 0, 49'h999);
    for (int i = 0; i < 3; i++) op0(1, 0, 0, 0, DW'(49'h500 + i));
    do_reset(1);
    op0(1, 0, 0, 0, 49'h600);
    op0(0, 1, 0, 0, '0);

    // Registered-read instance
    post1();
    op1(1, 0, 49'h11);
    op1(1, 0, 49'h22);
    op1(0, 1, '0);
    op1(0, 0, '0);
    op1(0, 0, '0);
    op1(0, 1, '0);
    op1(0, 0, '0);
    op1(0, 1, '0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
